// File: rtl/cr_prefix_fe_cmp_multi_if.sv
// Character stream, per-channel match configuration and registered feature
// outputs of the multi-channel prefix compare front end.
interface cr_prefix_fe_cmp_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic [DATA_W-1:0]        char_in;
    logic                     char_valid;
    logic                     char_eop;
    logic [NUM_CH*DATA_W-1:0] match_lo;
    logic [NUM_CH*DATA_W-1:0] match_hi;
    logic [NUM_CH*3-1:0]      cmp_type;
    logic [NUM_CH*CNT_W-1:0]  run_thresh;

    logic                     char_valid_r;
    logic                     eop_r;
    logic [NUM_CH-1:0]        cmp_r;
    logic [NUM_CH-1:0]        run_hit_r;
    logic [NUM_CH-1:0]        frame_hit_r;
    logic [NUM_CH*CNT_W-1:0]  run_cnt_r;

    modport master (
        output char_in, char_valid, char_eop, match_lo, match_hi, cmp_type, run_thresh,
        input  char_valid_r, eop_r, cmp_r, run_hit_r, frame_hit_r, run_cnt_r
    );

    modport slave (
        input  char_in, char_valid, char_eop, match_lo, match_hi, cmp_type, run_thresh,
        output char_valid_r, eop_r, cmp_r, run_hit_r, frame_hit_r, run_cnt_r
    );
endinterface

// File: rtl/cr_prefix_fe_cmp_multi.sv
// Multi-channel prefix comparator: per-channel compare modes, saturating
// run-length counting with threshold hits and a per-frame sticky hit summary.
module cr_prefix_fe_cmp_multi #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    cr_prefix_fe_cmp_multi_if.slave      bus
);
    typedef enum logic [2:0] {
        MODE_EQ    = 3'd0,
        MODE_GTEQ  = 3'd1,
        MODE_LT    = 3'd2,
        MODE_EQOP  = 3'd3,
        MODE_RANGE = 3'd4,
        MODE_NEQ   = 3'd5
    } cmp_mode_t;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } frame_state_t;

    frame_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] sticky_q;
    logic [NUM_CH-1:0] cmp_c;
    logic [NUM_CH-1:0] hit_c;
    logic              eop_valid;

    assign eop_valid = bus.char_valid & bus.char_eop;

    function automatic logic compare(input logic [2:0] mode, input logic [DATA_W-1:0] x,
                                     input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi);
        logic r;
        r = 1'b0;
        case (cmp_mode_t'(mode))
            MODE_EQ, MODE_EQOP: r = (x == lo);
            MODE_GTEQ:          r = (x >= lo);
            MODE_LT:            r = (x < lo);
            MODE_RANGE:         r = (x >= lo) && (x <= hi);
            MODE_NEQ:           r = (x != lo);
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.char_valid && !bus.char_eop) state_d = IN_FRAME;
            IN_FRAME: if (eop_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bubbles leave cnt_nxt equal to the held count, so the output register
    // can always load cnt_nxt.
    always_comb begin
        cmp_c = '0;
        hit_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            logic [2:0]       mode;
            logic [CNT_W-1:0] thr;
            logic [CNT_W-1:0] thr_eff;
            mode       = bus.cmp_type[c*3 +: 3];
            thr        = bus.run_thresh[c*CNT_W +: CNT_W];
            thr_eff    = (thr == '0) ? CNT_W'(1) : thr;
            cnt_nxt[c] = cnt_q[c];
            if (bus.char_valid) begin
                cmp_c[c] = compare(mode, bus.char_in,
                                   bus.match_lo[c*DATA_W +: DATA_W],
                                   bus.match_hi[c*DATA_W +: DATA_W]);
                if (cmp_c[c]) begin
                    if (cnt_q[c] != '1) cnt_nxt[c] = cnt_q[c] + CNT_W'(1);
                end else if (cmp_mode_t'(mode) != MODE_EQOP) begin
                    cnt_nxt[c] = '0;
                end
                hit_c[c] = cmp_c[c] && (cnt_nxt[c] >= thr_eff);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            sticky_q         <= '0;
            bus.char_valid_r <= 1'b0;
            bus.eop_r        <= 1'b0;
            bus.cmp_r        <= '0;
            bus.run_hit_r    <= '0;
            bus.frame_hit_r  <= '0;
            bus.run_cnt_r    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
        end else begin
            state_q          <= state_d;
            bus.char_valid_r <= bus.char_valid;
            bus.eop_r        <= eop_valid;
            bus.cmp_r        <= cmp_c;
            bus.run_hit_r    <= hit_c;
            bus.frame_hit_r  <= sticky_q | hit_c;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                bus.run_cnt_r[c*CNT_W +: CNT_W] <= cnt_nxt[c];
                cnt_q[c] <= eop_valid ? '0 : cnt_nxt[c];
            end
            sticky_q <= eop_valid ? '0 : (sticky_q | hit_c);
        end
    end
endmodule

// File: tb/tb_cr_prefix_fe_cmp_multi.sv
// Self-checking bench: constant vector tables, directed corner sequences and
// randomized traffic compared against a behavioural frame model.
module tb_cr_prefix_fe_cmp_multi;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cr_prefix_fe_cmp_multi_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    cr_prefix_fe_cmp_multi #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [7:0] ch;
        bit         v;
        bit         e;
        bit [3:0]   cmp;
        bit [3:0]   hit;
        int         cnt0;
        bit [3:0]   fh;
        bit         eop;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int       m_cnt    [NUM_CH];
    bit       m_sticky [NUM_CH];
    bit       e_valid, e_eop;
    bit [3:0] e_cmp, e_hit, e_fh;
    int       e_cnt    [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_match(input int mode, input int x, input int lo, input int hi);
        case (mode)
            0, 3:    return x == lo;
            1:       return x >= lo;
            2:       return x < lo;
            4:       return (x >= lo) && (x <= hi);
            5:       return x != lo;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_sticky[c] = 1'b0; e_cnt[c] = 0;
        end
        e_valid = 0; e_eop = 0; e_cmp = '0; e_hit = '0; e_fh = '0;
    endtask

    task automatic model_step(input int x, input bit v, input bit e);
        e_valid = v; e_eop = v && e; e_cmp = '0; e_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            int mode, lo, hi, thr, n;
            bit m, h;
            mode = int'(bus.cmp_type[c*3 +: 3]);
            lo   = int'(bus.match_lo[c*DATA_W +: DATA_W]);
            hi   = int'(bus.match_hi[c*DATA_W +: DATA_W]);
            thr  = int'(bus.run_thresh[c*CNT_W +: CNT_W]);
            if (v) begin
                m = ref_match(mode, x, lo, hi);
                if (m)              n = (m_cnt[c] + 1 > MAXC) ? MAXC : m_cnt[c] + 1;
                else if (mode == 3) n = m_cnt[c];
                else                n = 0;
                h = m && (n >= ((thr < 1) ? 1 : thr));
                e_cmp[c] = m; e_hit[c] = h; e_cnt[c] = n;
                e_fh[c]  = m_sticky[c] | h;
                if (e) begin
                    m_cnt[c] = 0; m_sticky[c] = 1'b0;
                end else begin
                    m_cnt[c] = n; m_sticky[c] = m_sticky[c] | h;
                end
            end else begin
                e_cnt[c] = m_cnt[c];
                e_fh[c]  = m_sticky[c];
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " valid_r"}, bus.char_valid_r, e_valid);
        check({tag, " eop_r"}, bus.eop_r, e_eop);
        check({tag, " cmp_r"}, bus.cmp_r, e_cmp);
        check({tag, " run_hit_r"}, bus.run_hit_r, e_hit);
        check({tag, " frame_hit_r"}, bus.frame_hit_r, e_fh);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s run_cnt%0d", tag, c), bus.run_cnt_r[c*CNT_W +: CNT_W], e_cnt[c]);
    endtask

    task automatic step(input string tag, input logic [7:0] x, input bit v, input bit e);
        @(negedge clk);
        bus.char_in = x; bus.char_valid = v; bus.char_eop = e;
        model_step(int'(x), v, e);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_ch(input int c, input int mode, input int lo, input int hi, input int thr);
        bus.cmp_type[c*3 +: 3]           = 3'(mode);
        bus.match_lo[c*DATA_W +: DATA_W] = 8'(lo);
        bus.match_hi[c*DATA_W +: DATA_W] = 8'(hi);
        bus.run_thresh[c*CNT_W +: CNT_W] = 4'(thr);
    endtask

    task automatic apply_vec(input string tag, input vec_t t);
        step(tag, t.ch, t.v, t.e);
        check({tag, " tbl cmp"}, bus.cmp_r, t.cmp);
        check({tag, " tbl hit"}, bus.run_hit_r, t.hit);
        check({tag, " tbl cnt0"}, bus.run_cnt_r[CNT_W-1:0], t.cnt0);
        check({tag, " tbl fh"}, bus.frame_hit_r, t.fh);
        check({tag, " tbl eop"}, bus.eop_r, t.eop);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid_r"}, bus.char_valid_r, 0);
        check({tag, " eop_r"}, bus.eop_r, 0);
        check({tag, " cmp_r"}, bus.cmp_r, 0);
        check({tag, " run_hit_r"}, bus.run_hit_r, 0);
        check({tag, " frame_hit_r"}, bus.frame_hit_r, 0);
        check({tag, " run_cnt_r"}, bus.run_cnt_r, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t sweep [4];
        vec_t runv  [7];
        int   eq_cnt   [3];
        int   eqop_cnt [3];
        logic [2:0] eq_cmp;
        logic [2:0] eq_eop;
        logic [2:0] eqop_hit;
        bit   in_frame;

        sweep[0] = '{8'h2F, 1, 0, 4'b1010, 4'b1010, 0, 4'b1010, 0};
        sweep[1] = '{8'h30, 1, 0, 4'b1101, 4'b1101, 1, 4'b1111, 0};
        sweep[2] = '{8'h39, 1, 0, 4'b1101, 4'b1101, 2, 4'b1111, 0};
        sweep[3] = '{8'h3A, 1, 1, 4'b1001, 4'b1001, 3, 4'b1111, 1};

        runv[0] = '{8'h20, 1, 0, 4'b0001, 4'b0000, 1, 4'b0000, 0};
        runv[1] = '{8'h20, 1, 0, 4'b0001, 4'b0000, 2, 4'b0000, 0};
        runv[2] = '{8'h20, 0, 0, 4'b0000, 4'b0000, 2, 4'b0000, 0};
        runv[3] = '{8'h20, 1, 0, 4'b0001, 4'b0001, 3, 4'b0001, 0};
        runv[4] = '{8'h20, 1, 0, 4'b0001, 4'b0001, 4, 4'b0001, 0};
        runv[5] = '{8'h41, 1, 0, 4'b0000, 4'b0000, 0, 4'b0001, 0};
        runv[6] = '{8'h20, 1, 1, 4'b0001, 4'b0000, 1, 4'b0001, 1};

        eq_cnt   = '{1, 0, 1};
        eqop_cnt = '{1, 1, 2};
        eq_cmp   = 3'b101;
        eq_eop   = 3'b100;
        eqop_hit = 3'b100;

        // Reset with traffic present: outputs must stay at zero
        rst = 1'b1;
        bus.char_in = '0; bus.char_valid = 1'b0; bus.char_eop = 1'b0;
        bus.match_lo = '0; bus.match_hi = '0; bus.cmp_type = '0; bus.run_thresh = '0;
        set_ch(0, 0, 8'h41, 0, 1);
        for (int c = 1; c < NUM_CH; c++) set_ch(c, 6, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.char_in = 8'h41; bus.char_valid = 1'b1; bus.char_eop = 1'(i);
            @(posedge clk); #1;
            check_zero("in_reset");
        end
        @(negedge clk);
        bus.char_valid = 1'b0; bus.char_eop = 1'b0;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) begin
            logic [7:0] x;
            x = (i == 1) ? 8'h42 : 8'h41;
            step("eq", x, 1'b1, i == 2);
            check("eq cmp0", bus.cmp_r[0], eq_cmp[i]);
            check("eq eop_r", bus.eop_r, eq_eop[i]);
        end

        set_ch(0, 1, 8'h30, 0, 0);
        set_ch(1, 2, 8'h30, 0, 0);
        set_ch(2, 4, 8'h30, 8'h39, 0);
        set_ch(3, 5, 8'h20, 0, 0);
        for (int i = 0; i < 4; i++) apply_vec($sformatf("sweep%0d", i), sweep[i]);

        set_ch(2, 4, 8'h40, 8'h30, 0);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] x;
            x = 8'(8'h30 + 8 * i);
            step("range_inv", x, 1'b1, i == 2);
            check("range_inv cmp2", bus.cmp_r[2], 0);
        end

        set_ch(0, 0, 8'h20, 0, 3);
        for (int c = 1; c < NUM_CH; c++) set_ch(c, 6, 0, 0, 0);
        for (int i = 0; i < 7; i++) apply_vec($sformatf("run%0d", i), runv[i]);

        set_ch(0, 0, 8'h61, 0, 2);
        set_ch(1, 3, 8'h61, 0, 2);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] x;
            x = (i == 1) ? 8'h62 : 8'h61;
            step("eqop", x, 1'b1, i == 2);
            check("eqop eq_cnt", bus.run_cnt_r[CNT_W-1:0], eq_cnt[i]);
            check("eqop eq_hit", bus.run_hit_r[0], 0);
            check("eqop op_cnt", bus.run_cnt_r[2*CNT_W-1:CNT_W], eqop_cnt[i]);
            check("eqop op_hit", bus.run_hit_r[1], eqop_hit[i]);
        end

        // Saturation, then a back-to-back frame that must start from zero
        set_ch(0, 0, 8'h20, 0, 15);
        set_ch(1, 6, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step("sat", 8'h20, 1'b1, i == 20);
            check("sat cnt0", bus.run_cnt_r[CNT_W-1:0], (i > 15) ? 15 : i);
            check("sat hit0", bus.run_hit_r[0], i >= 15);
        end
        step("b2b", 8'h20, 1'b1, 1'b0);
        check("b2b cnt0", bus.run_cnt_r[CNT_W-1:0], 1);
        check("b2b fh0", bus.frame_hit_r[0], 0);
        step("b2b_end", 8'h20, 1'b1, 1'b1);

        set_ch(0, 0, 8'h55, 0, 0);
        step("single", 8'h55, 1'b1, 1'b1);
        check("single hit0", bus.run_hit_r[0], 1);
        check("single fh0", bus.frame_hit_r[0], 1);
        check("single eop_r", bus.eop_r, 1);

        // Reset mid-frame with the eop character already on the inputs
        step("pre_rst", 8'h55, 1'b1, 1'b0);
        step("pre_rst", 8'h55, 1'b1, 1'b0);
        @(negedge clk);
        bus.char_in = 8'h55; bus.char_valid = 1'b1; bus.char_eop = 1'b1;
        #1 rst = 1'b1;
        #1 check_zero("midrst_async");
        @(posedge clk); #1;
        check_zero("midrst_held");
        @(negedge clk);
        bus.char_valid = 1'b0; bus.char_eop = 1'b0;
        rst = 1'b0;
        model_reset();
        step("post_rst", 8'h55, 1'b0, 1'b0);
        check("post_rst eop_r", bus.eop_r, 0);
        step("post_rst2", 8'h55, 1'b1, 1'b0);
        check("post_rst2 cnt0", bus.run_cnt_r[CNT_W-1:0], 1);
        step("post_rst3", 8'h55, 1'b1, 1'b1);

        in_frame = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bit v, e;
            if (!in_frame && ($urandom_range(0, 3) == 0)) begin
                for (int c = 0; c < NUM_CH; c++)
                    set_ch(c, $urandom_range(0, 7), $urandom_range(8'h28, 8'h3f),
                           $urandom_range(8'h28, 8'h3f),
                           ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 6));
            end else if (in_frame && ($urandom_range(0, 49) == 0)) begin
                bus.run_thresh[$urandom_range(0, NUM_CH-1)*CNT_W +: CNT_W] = 4'($urandom_range(0, 15));
            end
            v = ($urandom_range(0, 9) < 8);
            e = ($urandom_range(0, 5) == 0);
            step("rand", 8'($urandom_range(8'h28, 8'h3f)), v, e);
            if (v && e) in_frame = 1'b0;
            else if (v) in_frame = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
